// File: rtl/vga_timing_pkg.sv
// Timing constants and position decode for the 800x600 @ 60 Hz VGA timing generator.
// Every compare point is derived from the porch/sync widths below.
package vga_timing_pkg;

  localparam int COUNT_W  = 32'd11;

  localparam int H_ACTIVE = 32'd800;
  localparam int H_FP     = 32'd40;
  localparam int H_SYNC   = 32'd128;
  localparam int H_BP     = 32'd88;
  localparam int H_TOTAL  = 32'd1056;

  localparam int V_ACTIVE = 32'd600;
  localparam int V_FP     = 32'd1;
  localparam int V_SYNC   = 32'd4;
  localparam int V_BP     = 32'd23;
  localparam int V_TOTAL  = 32'd628;

  localparam logic [COUNT_W-1:0] H_LAST        = COUNT_W'(H_TOTAL - 32'd1);
  localparam logic [COUNT_W-1:0] H_BLANK_START = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] H_SYNC_START  = COUNT_W'(H_ACTIVE + H_FP);
  localparam logic [COUNT_W-1:0] H_SYNC_END    = COUNT_W'(H_ACTIVE + H_FP + H_SYNC - 32'd1);

  localparam logic [COUNT_W-1:0] V_LAST        = COUNT_W'(V_TOTAL - 32'd1);
  localparam logic [COUNT_W-1:0] V_BLANK_START = COUNT_W'(V_ACTIVE);
  localparam logic [COUNT_W-1:0] V_SYNC_START  = COUNT_W'(V_ACTIVE + V_FP);
  localparam logic [COUNT_W-1:0] V_SYNC_END    = COUNT_W'(V_ACTIVE + V_FP + V_SYNC - 32'd1);

  typedef struct packed {
    logic hsync;
    logic hblnk;
    logic vsync;
    logic vblnk;
    logic frame_tick;
  } vga_flags_t;

  // Position (0,0) decodes to all-zero, which lets reset and decode agree.
  function automatic vga_flags_t decode_pos(input logic [COUNT_W-1:0] h,
                                            input logic [COUNT_W-1:0] v);
    vga_flags_t f;
    f.hsync      = (h >= H_SYNC_START) && (h <= H_SYNC_END);
    f.hblnk      = (h >= H_BLANK_START);
    f.vsync      = (v >= V_SYNC_START) && (v <= V_SYNC_END);
    f.vblnk      = (v >= V_BLANK_START);
    f.frame_tick = (h == '0) && (v == V_BLANK_START);
    return f;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// 800x600 @ 60 Hz VGA timing: cascaded pixel/line counters with a registered decode
// of the next position, so counts, syncs and blanks always refer to the same pixel.
module vga_timing
  import vga_timing_pkg::*;
(
  input  logic               pclk_in,
  input  logic               rst_in,
  output logic [COUNT_W-1:0] hcount_out,
  output logic               hsync_out,
  output logic               hblnk_out,
  output logic [COUNT_W-1:0] vcount_out,
  output logic               vsync_out,
  output logic               vblnk_out,
  output logic               frame_tick_out
);

  logic [COUNT_W-1:0] h_cnt_r;
  logic [COUNT_W-1:0] v_cnt_r;
  logic [COUNT_W-1:0] h_nxt_s;
  logic [COUNT_W-1:0] v_nxt_s;
  vga_flags_t         flags_r;
  vga_flags_t         flags_nxt_s;

  // Next position; out-of-range counts wrap as if they were the last value.
  always_comb begin
    h_nxt_s = h_cnt_r;
    v_nxt_s = v_cnt_r;
    if (h_cnt_r >= H_LAST) begin
      h_nxt_s = '0;
      if (v_cnt_r >= V_LAST) begin
        v_nxt_s = '0;
      end else begin
        v_nxt_s = v_cnt_r + COUNT_W'(1);
      end
    end else begin
      h_nxt_s = h_cnt_r + COUNT_W'(1);
    end
  end

  // Decode is taken from the next position so it lands in the same cycle as the counts.
  always_comb begin
    flags_nxt_s = decode_pos(h_nxt_s, v_nxt_s);
  end

  // Counters and decoded flags advance together; reset forces position (0,0).
  always_ff @(posedge pclk_in) begin
    if (rst_in) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
      flags_r <= '0;
    end else begin
      h_cnt_r <= h_nxt_s;
      v_cnt_r <= v_nxt_s;
      flags_r <= flags_nxt_s;
    end
  end

  assign hcount_out     = h_cnt_r;
  assign vcount_out     = v_cnt_r;
  assign hsync_out      = flags_r.hsync;
  assign hblnk_out      = flags_r.hblnk;
  assign vsync_out      = flags_r.vsync;
  assign vblnk_out      = flags_r.vblnk;
  assign frame_tick_out = flags_r.frame_tick;

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The module SHALL have no parameters; all timing constants SHALL come from vga_timing_pkg (REQ-024).
REQ-002 pclk_in  input  1  pixel clock, 40 MHz; all state SHALL change on its rising edge only.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 hcount_out  output  11  horizontal pixel index, 0..1055.
REQ-005 hsync_out  output  1  horizontal sync, active-high.
REQ-006 hblnk_out  output  1  horizontal blanking, high outside the 800 active columns.
REQ-007 vcount_out  output  11  line index, 0..627.
REQ-008 vsync_out  output  1  vertical sync, active-high.
REQ-009 vblnk_out  output  1  vertical blanking, high outside the 600 active lines.
REQ-010 frame_tick_out  output  1  one-cycle pulse at the start of vertical blanking, for game-logic updates.

Function
REQ-011 Timing SHALL be 800x600 at 60 Hz.
- Horizontal: 800 active, 40 front porch, 128 sync, 88 back porch; 1056 total.
- Vertical: 600 active, 1 front porch, 4 sync, 23 back porch; 628 total.
REQ-012 hcount_out SHALL increment by 1 every pclk_in cycle while rst_in is low.
REQ-013 When hcount_out is 1055, the next cycle SHALL give hcount_out=0, and vcount_out SHALL increment.
REQ-014 When hcount_out=1055 and vcount_out=627 in the same cycle, the next cycle SHALL give hcount_out=0 and vcount_out=0.
REQ-015 hblnk_out SHALL be high iff hcount_out>=800.
REQ-016 hsync_out SHALL be high iff 840<=hcount_out<=967.
REQ-017 vblnk_out SHALL be high iff vcount_out>=600.
REQ-018 vsync_out SHALL be high iff 601<=vcount_out<=604.
REQ-019 frame_tick_out SHALL be high iff hcount_out=0 and vcount_out=600; this gives exactly one pulse per 663168 cycles.
REQ-020 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-021 All seven outputs in a given cycle SHALL describe the same (hcount_out, vcount_out) position: zero skew between counts, syncs and blanks.
REQ-022 Counters SHALL never show values above 1055 (horizontal) or 627 (vertical), including the cycle after reset.

Reset
REQ-023 While rst_in is high at a clock edge, all outputs SHALL be driven to 0 on that edge.
- This state equals the decode of position (0,0).
- Reset asserted mid-frame SHALL abort the frame immediately, with no completion of the current line.
- The first edge with rst_in low SHALL produce hcount_out=1, vcount_out=0.

Structure
REQ-024 vga_timing_pkg SHALL hold:
- H_ACTIVE=800, H_FP=40, H_SYNC=128, H_BP=88, H_TOTAL=1056;
- V_ACTIVE=600, V_FP=1, V_SYNC=4, V_BP=23, V_TOTAL=628;
- COUNT_W=11.
REQ-025 Derived compare points SHALL be computed from the package constants, not written as literals: sync start = ACTIVE+FP; sync end = ACTIVE+FP+SYNC-1.
REQ-026 No sub-module SHALL be used; the block is two cascaded counters plus a registered decode, in one module.

Verification
REQ-027 Reset hold then release: rst_in high 3 cycles -> all outputs 0; first cycle after release -> hcount_out=1, vcount_out=0, hblnk_out=0.
REQ-028 Line wrap: run to hcount_out=1055, vcount_out=5 -> next cycle hcount_out=0, vcount_out=6; hsync_out high for exactly 128 cycles per line, starting at hcount_out=840.
REQ-029 Frame wrap: run to (1055,627) -> next cycle (0,0) with vblnk_out=0, hblnk_out=0; vsync_out high exactly on lines 601..604 (4x1056 cycles).
REQ-030 frame_tick_out over 3 full frames: exactly 3 pulses, each 1 cycle wide, each at (0,600), spaced 663168 cycles apart.
REQ-031 Mid-frame reset: assert rst_in at (500,300) for 1 cycle -> outputs 0 on that edge, then (1,0) on the next, with no frame_tick_out pulse.
REQ-032 Scoreboard for the whole run: every cycle, every output equals a reference model decoded from the counts; active pixel count per frame = 480000.
